stream_burst_drop: RTL and testbench



---
 rtl/stream_burst_drop_pkg.sv | 14 +
 rtl/stream_burst_drop_cnt.sv | 24 ++
 rtl/stream_burst_drop.sv | 99 +++++++++
 tb/tb_stream_burst_drop.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/stream_burst_drop_pkg.sv
// Shared types and constants for the burst-aware drop controller.
package stream_burst_drop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } burst_state_e;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_PASS = PASS;
    localparam logic [1:0] ST_DROP = DROP;

endpackage

// File: rtl/stream_burst_drop_cnt.sv
// Saturating up-counter with a synchronous clear that overrides the increment.
module stream_burst_drop_cnt #(
    parameter int CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                en_i,
    output logic [CntWidth-1:0] cnt_o
);

    logic [CntWidth-1:0] cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_reg <= '0;
        end else if (en_i && (cnt_reg != {CntWidth{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt_o = cnt_reg;

endmodule

// File: rtl/stream_burst_drop.sv
// Locks a drop/pass decision on the first beat of each burst until its last beat handshakes.
// Burst statistics are compiled in only when STREAM_BURST_DROP_CNT_EN is defined.
module stream_burst_drop
    import stream_burst_drop_pkg::*;
#(
    parameter int CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    input  logic                ready_i,
    input  logic                last_i,
    input  logic                drop_req_i,
    output logic                drop_o,
    output logic                busy_o,
    input  logic                clr_i,
    output logic [CntWidth-1:0] drop_cnt_o,
    output logic [CntWidth-1:0] pass_cnt_o
);

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic       handshake;

    assign handshake = valid_i && ready_i;

    // The request is honoured only while idle, so drop_o never looks at ready_i.
    always_comb begin
        drop_o = 1'b0;
        case (state_reg)
            ST_IDLE: drop_o = drop_req_i;
            ST_DROP: drop_o = 1'b1;
            default: drop_o = 1'b0;
        endcase
    end

    assign busy_o = (state_reg != ST_IDLE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (handshake && !last_i) begin
                    state_next = drop_req_i ? ST_DROP : ST_PASS;
                end
            end
            ST_PASS, ST_DROP: begin
                if (handshake && last_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

`ifdef STREAM_BURST_DROP_CNT_EN
    logic drop_evt;
    logic pass_evt;

    // drop_o already carries the burst's decision on its last beat, including single-beat bursts.
    assign drop_evt = handshake && last_i && drop_o;
    assign pass_evt = handshake && last_i && !drop_o;

    stream_burst_drop_cnt #(
        .CntWidth(CntWidth)
    ) u_drop_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .en_i  (drop_evt),
        .cnt_o (drop_cnt_o)
    );

    stream_burst_drop_cnt #(
        .CntWidth(CntWidth)
    ) u_pass_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .en_i  (pass_evt),
        .cnt_o (pass_cnt_o)
    );
`else
    logic unused_clr;

    assign unused_clr = clr_i;
    assign drop_cnt_o = '0;
    assign pass_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stream_burst_drop.sv
// Directed bench for stream_burst_drop: a default-width and a 2-bit-counter instance share stimulus.
module tb_stream_burst_drop;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, valid, last, drop_req, down_ready, clr;
    logic ready_a, ready_b, drop_a, drop_b, busy_a, busy_b;
    logic [15:0] dcnt_a, pcnt_a;
    logic [1:0]  dcnt_b, pcnt_b;

    // Filter emulation: a dropped beat is always accepted.
    assign ready_a = down_ready | drop_a;
    assign ready_b = down_ready | drop_b;

    stream_burst_drop #(.CntWidth(16)) dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_i(ready_a), .last_i(last),
        .drop_req_i(drop_req), .drop_o(drop_a), .busy_o(busy_a), .clr_i(clr),
        .drop_cnt_o(dcnt_a), .pass_cnt_o(pcnt_a)
    );

    stream_burst_drop #(.CntWidth(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_i(ready_b), .last_i(last),
        .drop_req_i(drop_req), .drop_o(drop_b), .busy_o(busy_b), .clr_i(clr),
        .drop_cnt_o(dcnt_b), .pass_cnt_o(pcnt_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected count for literal checks: counters read 0 when statistics are not built.
    function automatic int e(input int n);
`ifdef STREAM_BURST_DROP_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    // Model: a burst either is or is not open; an open burst remembers its first-beat decision.
    bit m_open = 1'b0;
    bit m_dec  = 1'b0;
    int m_da = 0, m_pa = 0, m_db = 0, m_pb = 0;

    function automatic bit m_drop();
        return m_open ? m_dec : drop_req;
    endfunction

    always @(posedge clk) begin : model
        bit d;
        bit hs;
        d  = m_drop();
        hs = valid && (down_ready || d);
        if (rst) begin
            m_open = 1'b0;
            m_dec  = 1'b0;
            m_da = 0; m_pa = 0; m_db = 0; m_pb = 0;
        end else begin
            if (hs) begin
                if (last) begin
`ifdef STREAM_BURST_DROP_CNT_EN
                    if (d) begin
                        if (m_da < 65535) m_da++;
                        if (m_db < 3) m_db++;
                    end else begin
                        if (m_pa < 65535) m_pa++;
                        if (m_pb < 3) m_pb++;
                    end
`endif
                    m_open = 1'b0;
                end else begin
                    m_open = 1'b1;
                    m_dec  = d;
                end
            end
`ifdef STREAM_BURST_DROP_CNT_EN
            if (clr) begin
                m_da = 0; m_pa = 0; m_db = 0; m_pb = 0;
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("drop_a", {31'd0, drop_a}, {31'd0, m_drop()});
            chk("busy_a", {31'd0, busy_a}, {31'd0, m_open});
            chk("dcnt_a", {16'd0, dcnt_a}, m_da);
            chk("pcnt_a", {16'd0, pcnt_a}, m_pa);
            chk("drop_b", {31'd0, drop_b}, {31'd0, m_drop()});
            chk("busy_b", {31'd0, busy_b}, {31'd0, m_open});
            chk("dcnt_b", {30'd0, dcnt_b}, m_db);
            chk("pcnt_b", {30'd0, pcnt_b}, m_pb);
        end
    end

    task automatic beat(input bit v, input bit l, input bit req, input bit rdy, input bit c);
        valid = v; last = l; drop_req = req; down_ready = rdy; clr = c;
        #1;
        $display("beat v=%0b last=%0b req=%0b rdy=%0b clr=%0b rst=%0b -> drop=%0b busy=%0b dcnt=%0d pcnt=%0d",
                 v, l, req, rdy, c, rst, drop_a, busy_a, dcnt_a, pcnt_a);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; last = 1'b0; drop_req = 1'b0; down_ready = 1'b0; clr = 1'b0;
        @(posedge clk); #1;
        checking = 1'b1;
        @(posedge clk); #1;
        chk("reset_busy", {31'd0, busy_a}, 32'd0);
        chk("reset_dcnt", {16'd0, dcnt_a}, 32'd0);
        rst = 1'b0;

        // Idle: drop_o follows the request combinationally.
        drop_req = 1'b1; #1;
        chk("idle_drop_follows_req", {31'd0, drop_a}, 32'd1);
        beat(0, 0, 1, 0, 0);

        // 4-beat dropped burst, request withdrawn after beat 0, downstream stalls ignored.
        beat(1, 0, 1, 1, 0);
        chk("drop_burst_busy", {31'd0, busy_a}, 32'd1);
        beat(1, 0, 0, 0, 0);
        beat(1, 0, 0, 1, 0);
        drop_req = 1'b0; #1;
        chk("drop_burst_locked", {31'd0, drop_a}, 32'd1);
        beat(1, 1, 0, 0, 0);
        chk("drop_cnt_1", {16'd0, dcnt_a}, e(1));
        chk("drop_burst_done", {31'd0, busy_a}, 32'd0);

        // 3-beat passed burst with a 5-cycle stall and a toggling request.
        beat(1, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) beat(1, 0, i[0] ? 1'b0 : 1'b1, 0, 0);
        chk("pass_burst_held", {31'd0, busy_a}, 32'd1);
        beat(1, 0, 1, 1, 0);
        beat(1, 1, 1, 1, 0);
        chk("pass_cnt_1", {16'd0, pcnt_a}, e(1));

        // 8 back-to-back single-beat bursts alternating drop/pass.
        for (int i = 0; i < 8; i++) beat(1, 1, i[0] ? 1'b0 : 1'b1, 1, 0);
        chk("singles_dcnt_a", {16'd0, dcnt_a}, e(5));
        chk("singles_pcnt_a", {16'd0, pcnt_a}, e(5));
        chk("singles_dcnt_b_sat", {30'd0, dcnt_b}, e(3));

        // Clear coinciding with a counted last beat wins.
        beat(1, 1, 1, 1, 1);
        chk("clr_priority_a", {16'd0, dcnt_a}, 32'd0);
        chk("clr_priority_b", {30'd0, dcnt_b}, 32'd0);
        for (int i = 0; i < 5; i++) beat(1, 1, 1, 0, 0);
        chk("sat_dcnt_b", {30'd0, dcnt_b}, e(3));
        chk("nosat_dcnt_a", {16'd0, dcnt_a}, e(5));

        // Reset on beat 2 of a dropped burst; the next beat starts fresh.
        beat(1, 0, 1, 1, 0);
        beat(1, 0, 1, 1, 0);
        rst = 1'b1;
        beat(1, 0, 1, 1, 0);
        rst = 1'b0;
        chk("rst_mid_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_mid_dcnt", {16'd0, dcnt_a}, 32'd0);
        drop_req = 1'b0; valid = 1'b1; #1;
        chk("rst_mid_next_pass", {31'd0, drop_a}, 32'd0);
        beat(1, 0, 0, 1, 0);
        beat(1, 1, 1, 1, 0);
        chk("rst_mid_pass_cnt", {16'd0, pcnt_a}, e(1));

        beat(0, 0, 0, 0, 0);
        beat(0, 0, 0, 0, 0);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
